// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Holds the PC, fetches one word at a time over a req/ack handshake and
// presents it to decode, with downstream stall and halt/resume support.
// Optional feature macro: FETCH_TIMEOUT_EN adds a fetch-ack timeout that
// raises a sticky fetch_err and parks the block in HALT.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc_in,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        resume,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        halted,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      StFetch = 2'b00,
      StExec  = 2'b01,
      StHalt  = 2'b10
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic        w_timeout;

   // The two low PC bits are forced to zero, so next_pc_in[1:0] is never consumed.
   logic w_unused_low_bits;
   assign w_unused_low_bits = ^next_pc_in[1:0];

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);

   logic [CntW-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic            r_fetch_err, w_fetch_err_nxt;

   // Timeout fires on the MAX_WAIT-th consecutive FETCH cycle without ack.
   assign w_timeout = (r_state == StFetch) && !imem_ack &&
                      ((32'(r_wait_cnt) + 32'd1) == MAX_WAIT);

   // Wait counter counts ack-less FETCH cycles; it sits at zero outside FETCH,
   // which clears it for every entry into FETCH. The error flag is sticky.
   always_comb begin
      w_wait_cnt_nxt  = '0;
      w_fetch_err_nxt = r_fetch_err;
      if ((r_state == StFetch) && !imem_ack) begin
         w_wait_cnt_nxt = CntW'(r_wait_cnt + 1'b1);
      end
      if (w_timeout) begin
         w_fetch_err_nxt = 1'b1;
      end
   end

   // Timeout state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt  <= '0;
         r_fetch_err <= 1'b0;
      end else begin
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_fetch_err <= w_fetch_err_nxt;
      end
   end

   assign fetch_err = r_fetch_err;
`else
   logic w_unused_max_wait;
   assign w_unused_max_wait = (MAX_WAIT != 0);
   assign w_timeout         = 1'b0;
   assign fetch_err         = 1'b0;
`endif

   // State, PC and instruction registers; reset aborts any fetch in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StFetch;
         r_pc    <= RESET_PC;
         r_instr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
      end
   end

   // Next-state logic: fetch until ack, execute (honouring stall), halt until resume.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      unique case (r_state)
         StFetch: begin
            if (imem_ack) begin
               w_instr_nxt = imem_rdata;
               w_state_nxt = StExec;
            end else if (w_timeout) begin
               w_state_nxt = StHalt;
            end
         end
         StExec: begin
            // Stall outranks halt_req: everything holds while stalled.
            if (!stall) begin
               w_pc_nxt    = {next_pc_in[31:2], 2'b00};
               w_state_nxt = halt_req ? StHalt : StFetch;
            end
         end
         StHalt: begin
            if (resume) begin
               w_state_nxt = StFetch;
            end
         end
         default: begin
            w_state_nxt = StFetch;
         end
      endcase
   end

   // Output decode.
   always_comb begin
      pc          = r_pc;
      pc_plus4    = r_pc + 32'd4;
      imem_addr   = r_pc;
      imem_req    = (r_state == StFetch);
      instr       = r_instr;
      instr_valid = (r_state == StExec);
      halted      = (r_state == StHalt);
   end

endmodule
